// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, skid-free instruction hold.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misalign_o
`endif
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            stale_q, stale_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            owed;
  logic            granted;
  logic [XLEN-1:0] target;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            misalign_q, misalign_d;
  logic            park_q, park_d;
`endif

  // Next-state, pc and output computation.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
    park_d     = park_q;
    target     = redirect_pc_i;
`else
    target     = redirect_pc_i & ~ALIGN_MASK;
`endif
    // owed: a response beat is still due from a request we no longer want
    owed    = kill_q | stale_q;
    granted = req_q & imem_gnt_i;
    kill_d  = owed & ~imem_rvalid_i;
    // Beat owed across a reset is remembered so it can be dropped afterwards
    stale_d = rst ? (((owed | (state_q == WAIT)) & ~imem_rvalid_i) | granted) : 1'b0;

    unique case (state_q)
      IDLE: begin
`ifdef FETCH_MISALIGN_TRAP_EN
        if (!park_q) state_d = REQ;
`else
        state_d = REQ;
`endif
      end
      REQ: begin
        if (granted) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid_i && !owed) begin
          valid_d   = 1'b1;
          inst_d    = imem_rdata_i;
          inst_pc_d = pc_q;
          pc_d      = pc_q + XLEN'(INST_BYTES);
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (inst_ready_i) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect flushes everything; an in-flight or same-cycle-granted request is killed.
    if (redirect_i) begin
      valid_d = 1'b0;
      kill_d  = kill_d | ((state_q == WAIT) & ~imem_rvalid_i) | granted;
`ifdef FETCH_MISALIGN_TRAP_EN
      if ((redirect_pc_i & ALIGN_MASK) != '0) begin
        misalign_d = 1'b1;
        park_d     = 1'b1;
        state_d    = IDLE;
      end else begin
        park_d  = 1'b0;
        pc_d    = target;
        state_d = REQ;
      end
`else
      pc_d    = target;
      state_d = REQ;
`endif
    end

    req_d  = (state_d == REQ) & ~kill_d;
    addr_d = pc_d;
  end

  always_ff @(posedge clk) begin
    stale_q <= stale_d;
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      kill_q    <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= RESET_PC;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
      park_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      kill_q    <= kill_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
      park_q     <= park_d;
`endif
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_o   = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed stimulus, queue of expected (pc, inst), decoupled monitor.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int          total = 0;
  int          bad   = 0;
  logic [63:0] sb[$];
  logic        gnt_en;
  int          lat;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_o    (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  assign imem_gnt_i = imem_req_o & gnt_en;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // Instruction memory: one beat 'lat' cycles after each grant.
  initial begin
    bit          pending;
    int          cnt;
    logic [31:0] paddr;
    pending = 1'b0;
    cnt = 0;
    paddr = '0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      imem_rvalid_i = 1'b0;
      if (pending) begin
        if (cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_word(paddr);
          pending = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (imem_req_o === 1'b1 && imem_gnt_i === 1'b1) begin
        pending = 1'b1;
        cnt     = lat - 1;
        paddr   = imem_addr_o;
      end
    end
  end

  // Monitor: every completed handshake is checked against the scoreboard.
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && inst_valid_o === 1'b1 && inst_ready_i === 1'b1 && redirect_i === 1'b0) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_inst: got pc=%h inst=%h, required no instruction", inst_pc_o, inst_o);
        end else begin
          exp = sb.pop_front();
          if ({inst_pc_o, inst_o} !== exp) begin
            bad++;
            $display("FAIL inst: got pc=%h inst=%h, required pc=%h inst=%h",
                     inst_pc_o, inst_o, exp[63:32], exp[31:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (inst_valid_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (inst_valid_o !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s: inst_valid_o=%b after 50 cycles, required 1", name, inst_valid_o);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (imem_req_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (imem_req_o !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s: imem_req_o=%b after 50 cycles, required 1", name, imem_req_o);
    end
  endtask

  task automatic accept(input logic [31:0] pc);
    wait_valid("accept_timeout");
    sb.push_back({pc, mem_word(pc)});
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    inst_ready_i  = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    gnt_en        = 1'b1;
    lat           = 1;
    repeat (3) tick();

    check("rst_req",     32'(imem_req_o),   32'h0);
    check("rst_addr",    imem_addr_o,       32'h0);
    check("rst_valid",   32'(inst_valid_o), 32'h0);
    check("rst_inst",    inst_o,            32'h0);
    check("rst_inst_pc", inst_pc_o,         32'h0);

    // First fetches: request one cycle after release, valid two cycles after request.
    rst = 1'b0;
    tick();
    check("first_req",  32'(imem_req_o), 32'h1);
    check("first_addr", imem_addr_o,     32'h0);
    tick();
    check("wait_no_req", 32'(imem_req_o), 32'h0);
    tick();
    check("lat_valid",  32'(inst_valid_o), 32'h1);
    check("lat_pc",     inst_pc_o,         32'h0);
    accept(32'h0);
    check("next_req",  32'(imem_req_o), 32'h1);
    check("next_addr", imem_addr_o,     32'h4);
    accept(32'h4);
    accept(32'h8);

    // Decoder stall in HOLD: outputs stable, no new request.
    wait_valid("hold_timeout");
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(inst_valid_o), 32'h1);
      check("hold_pc",    inst_pc_o,         32'hC);
      check("hold_inst",  inst_o,            mem_word(32'hC));
      check("hold_req",   32'(imem_req_o),   32'h0);
      tick();
    end
    lat = 3;
    accept(32'hC);
    check("release_req",  32'(imem_req_o), 32'h1);
    check("release_addr", imem_addr_o,     32'h10);

    // Redirect while waiting: the 0x10 response must be dropped.
    tick();
    check("wait_req_low", 32'(imem_req_o), 32'h0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    lat = 2;
    wait_req("redir_wait_timeout");
    check("redir_wait_addr", imem_addr_o, 32'h100);
    accept(32'h100);

    // Redirect together with ready in HOLD.
    wait_valid("hold2_timeout");
    inst_ready_i  = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    tick();
    inst_ready_i = 1'b0;
    redirect_i   = 1'b0;
    check("redir_hold_valid", 32'(inst_valid_o), 32'h0);
    check("redir_hold_req",   32'(imem_req_o),   32'h1);
    check("redir_hold_addr",  imem_addr_o,       32'h200);
    accept(32'h200);

    // Redirect in REQ coinciding with a grant, then pc wrap at the top of the map.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    wait_req("wrap_req_timeout");
    check("wrap_top_addr", imem_addr_o, 32'hFFFF_FFFC);
    accept(32'hFFFF_FFFC);
    check("wrap_req",  32'(imem_req_o), 32'h1);
    check("wrap_addr", imem_addr_o,     32'h0);
    accept(32'h0);

    // Request held stable without grant, then redirected.
    gnt_en = 1'b0;
    repeat (2) tick();
    check("stall_req",  32'(imem_req_o), 32'h1);
    check("stall_addr", imem_addr_o,     32'h4);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h300;
    tick();
    redirect_i = 1'b0;
    check("redir_req_req",  32'(imem_req_o), 32'h1);
    check("redir_req_addr", imem_addr_o,     32'h300);
    gnt_en = 1'b1;
    accept(32'h300);

    // Misaligned redirect.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h102;
    tick();
    redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_pulse", 32'(misalign_o),   32'h1);
    check("mis_req",   32'(imem_req_o),   32'h0);
    check("mis_valid", 32'(inst_valid_o), 32'h0);
    tick();
    check("mis_clear", 32'(misalign_o), 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("mis_park_req", 32'(imem_req_o), 32'h0);
      tick();
    end
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    tick();
    redirect_i = 1'b0;
    check("unpark_req",  32'(imem_req_o), 32'h1);
    check("unpark_addr", imem_addr_o,     32'h200);
    accept(32'h200);
`else
    wait_req("mis_req_timeout");
    check("mis_forced_addr", imem_addr_o, 32'h100);
    accept(32'h100);
`endif

    // Reset while WAIT is active: the late response must be ignored.
    lat = 4;
    tick();
    check("pre_rst_wait_req", 32'(imem_req_o), 32'h0);
    rst = 1'b1;
    tick();
    check("midrst_valid", 32'(inst_valid_o), 32'h0);
    check("midrst_req",   32'(imem_req_o),   32'h0);
    check("midrst_addr",  imem_addr_o,       32'h0);
    check("midrst_inst",  inst_o,            32'h0);
    rst = 1'b0;
    lat = 1;
    wait_req("post_rst_req_timeout");
    check("post_rst_addr", imem_addr_o, 32'h0);
    accept(32'h0);

    repeat (5) tick();
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
